vending_ctrl: RTL
=================

VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameter PRICE_UNITS, default 4, item price in 5-cent units (20 cents).
REQ-002 Parameter N_ITEMS, default 4, number of product channels.
REQ-003 Parameter CREDIT_W, default 6, width of the credit register in 5-cent units.
REQ-004 Parameter MAX_CREDIT, default 20, maximum accepted credit in units ($1.00); SHALL satisfy PRICE_UNITS <= MAX_CREDIT < 2**CREDIT_W.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 i_nickle / i_dime / i_quarter  input  1 each  coin-present strobes worth 1 / 2 / 5 units.
REQ-008 i_sel  input  N_ITEMS  product select request, any bits.
REQ-009 i_stock  input  N_ITEMS  per-channel stock-available flags.
REQ-010 i_cancel  input  1  refund request.
REQ-011 o_vend  output  N_ITEMS  one-hot dispense pulse, one cycle.
REQ-012 o_change_nickle  output  1  one pulse per nickel of change returned.
REQ-013 o_coin_reject  output  1  one-cycle pulse: a strobed coin was not credited.
REQ-014 o_sel_err  output  1  one-cycle pulse: selection refused.
REQ-015 o_credit  output  CREDIT_W  current credit in units.
REQ-016 o_busy  output  1  high in VEND and CHANGE states.

Function
REQ-017 FSM states SHALL be IDLE (credit 0), CREDIT, VEND and CHANGE; all outputs SHALL be registered.
REQ-018 In IDLE/CREDIT, only the highest-priority coin (nickle > dime > quarter) SHALL be credited at the sampling edge; any other coin strobed in that cycle SHALL cause o_coin_reject the next cycle.
REQ-019 A coin that would push credit above MAX_CREDIT SHALL be rejected, leaving credit unchanged.
REQ-020 An accepted coin SHALL update o_credit at the same edge and move IDLE->CREDIT.
REQ-021 In CREDIT with i_sel nonzero, the lowest-index set bit SHALL be the selected channel.
- Valid (credit >= PRICE_UNITS and i_stock[ch]=1): next state VEND, credit -= PRICE_UNITS at that edge.
- Otherwise: o_sel_err pulse, credit kept.
REQ-022 A selection and coins in the same cycle: selection SHALL be evaluated on the pre-edge credit; if valid, all coins SHALL be rejected; if invalid, coins SHALL be processed per REQ-018/019.
REQ-023 VEND SHALL last exactly one cycle with o_vend[ch]=1, then go to CHANGE if credit > 0, else IDLE.
REQ-024 CHANGE SHALL assert o_change_nickle on consecutive cycles, decrementing credit by 1 per cycle, and enter IDLE on the edge credit reaches 0.
REQ-025 i_cancel in CREDIT SHALL enter CHANGE (full refund); cancel has priority over selection and coins (coins rejected); cancel in IDLE/VEND/CHANGE SHALL be ignored.
REQ-026 Coins strobed in VEND or CHANGE SHALL be rejected; i_sel in IDLE, VEND or CHANGE SHALL be ignored without o_sel_err.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, credit 0 and every output 0, including mid-VEND or mid-CHANGE (outstanding change is forfeited).
REQ-028 The first active edge after reset_n rises SHALL behave as a normal IDLE cycle.

Configuration
REQ-029 Macro VEND_AUDIT_EN defined: add output o_sales_cnt (16 bits, reset 0), incremented at each VEND entry and saturating at 16'hFFFF; undefined: the port and counter SHALL NOT exist and all other behaviour SHALL be identical.

Verification
REQ-030 nickle, nickle, dime, then i_sel=0001, i_stock=1111 -> o_vend=0001 for one cycle, credit 0, no o_change_nickle pulses, IDLE.
REQ-031 quarter, then i_sel=0100 -> o_vend=0100, then one o_change_nickle pulse, credit 1->0, IDLE.
REQ-032 four quarters (credit 20), then nickle -> o_coin_reject, credit 20; i_cancel -> 20 consecutive o_change_nickle pulses, o_busy high throughout.
REQ-033 dime, then i_sel=0010 with i_stock=1101 -> o_sel_err pulse, credit stays 2, state CREDIT.
REQ-034 nickle+dime same cycle from IDLE -> credit 1, one o_coin_reject pulse.
REQ-035 reset_n low after 3 of 5 change pulses -> all outputs 0 with no clock edge; no further pulses after release.

Source files
------------

// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------
// vending_ctrl
//
// Coin-operated vending controller. It accepts nickels, dimes and quarters,
// tracks credit in 5-cent units, dispenses one item per valid selection and
// returns change one nickel per cycle. All outputs come straight from
// flip-flops.
//
// Parameters
//   PRICE_UNITS  item price in 5-cent units
//   N_ITEMS      number of product channels
//   CREDIT_W     width of the credit register
//   MAX_CREDIT   highest credit the machine will hold
//                (PRICE_UNITS <= MAX_CREDIT < 2**CREDIT_W, CREDIT_W >= 3)
//
// Ports
//   i_clk            clock, everything updates on the rising edge
//   reset_n          asynchronous active-low reset
//   i_nickle         nickel strobe (1 unit)
//   i_dime           dime strobe (2 units)
//   i_quarter        quarter strobe (5 units)
//   i_sel            product select request, any number of bits
//   i_stock          per-channel stock available flags
//   i_cancel         refund request
//   o_vend           one-hot, one-cycle dispense pulse
//   o_change_nickle  one pulse per nickel of change returned
//   o_coin_reject    one-cycle pulse, a strobed coin was not credited
//   o_sel_err        one-cycle pulse, a selection was refused
//   o_credit         current credit in units
//   o_sales_cnt      saturating count of vends (only with VEND_AUDIT_EN)
//   o_busy           high while vending or returning change
//
// Optional feature: define VEND_AUDIT_EN to add the o_sales_cnt port and
// its 16-bit saturating sales counter.
// ---------------------------------------------------------------------------
module vending_ctrl #(
   parameter int PRICE_UNITS = 4,
   parameter int N_ITEMS     = 4,
   parameter int CREDIT_W    = 6,
   parameter int MAX_CREDIT  = 20
) (
   input  logic                i_clk,
   input  logic                reset_n,
   input  logic                i_nickle,
   input  logic                i_dime,
   input  logic                i_quarter,
   input  logic [N_ITEMS-1:0]  i_sel,
   input  logic [N_ITEMS-1:0]  i_stock,
   input  logic                i_cancel,
   output logic [N_ITEMS-1:0]  o_vend,
   output logic                o_change_nickle,
   output logic                o_coin_reject,
   output logic                o_sel_err,
   output logic [CREDIT_W-1:0] o_credit,
`ifdef VEND_AUDIT_EN
   output logic [15:0]         o_sales_cnt,
`endif
   output logic                o_busy
);

   localparam int SUM_W = CREDIT_W + 1;

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
   localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
   localparam logic [SUM_W-1:0]    MAX_EXT = SUM_W'(MAX_CREDIT);

   typedef enum logic [1:0] {
      IDLE,
      CREDIT,
      VEND,
      CHANGE
   } state_t;

   state_t state;
   state_t state_next;

   logic [CREDIT_W-1:0] credit_next;
   logic [N_ITEMS-1:0]  vend_next;
   logic                change_next;
   logic                reject_next;
   logic                sel_err_next;
   logic                busy_next;

   logic                coin_any;
   logic                coin_loser;
   logic [SUM_W-1:0]    coin_val;
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_fits;
   logic                coin_accept;
   logic                coin_reject_normal;

   logic [N_ITEMS-1:0]  sel_onehot;
   logic                sel_any;
   logic                sel_valid;

   // Coin arbitration. Only one coin can be credited per edge, so the
   // nickel wins over the dime and the dime wins over the quarter. Any coin
   // that loses arbitration is bounced back. The winning coin is also
   // bounced if it would take the credit past the ceiling; in that case the
   // credit is left untouched. The sum is one bit wider than the credit
   // register so the ceiling check can never wrap.
   always_comb begin
      coin_any   = i_nickle | i_dime | i_quarter;
      coin_val   = '0;
      coin_loser = 1'b0;
      if (i_nickle) begin
         coin_val   = SUM_W'(1);
         coin_loser = i_dime | i_quarter;
      end else if (i_dime) begin
         coin_val   = SUM_W'(2);
         coin_loser = i_quarter;
      end else if (i_quarter) begin
         coin_val   = SUM_W'(5);
      end
      coin_sum           = {1'b0, o_credit} + coin_val;
      coin_fits          = (coin_sum <= MAX_EXT);
      coin_accept        = coin_any && coin_fits;
      coin_reject_normal = coin_any && (!coin_fits || coin_loser);
   end

   // Selection decode. The lowest-index requested channel is the one that
   // counts, isolated with the two's-complement trick. If that channel is
   // out of stock the request is refused even when a higher channel has
   // stock, because the customer asked for the lowest one first.
   always_comb begin
      sel_onehot = i_sel & (~i_sel + N_ITEMS'(1));
      sel_any    = |i_sel;
      sel_valid  = sel_any && (o_credit >= PRICE_C) &&
                   (|(sel_onehot & i_stock));
   end

   // Next-state and next-output logic. Every output is computed here one
   // cycle ahead and then registered, so what leaves the block is glitch
   // free. Cancel beats selection, which beats coins. In VEND and CHANGE
   // every coin is bounced, and selection and cancel are ignored. CHANGE
   // pays out one nickel per cycle and leaves on the edge where credit
   // hits zero. This gives exactly as many pulses as there was credit on
   // entry.
   always_comb begin
      state_next   = state;
      credit_next  = o_credit;
      vend_next    = '0;
      reject_next  = 1'b0;
      sel_err_next = 1'b0;
      change_next  = 1'b0;
      busy_next    = 1'b0;

      case (state)
         IDLE: begin
            reject_next = coin_reject_normal;
            if (coin_accept) begin
               credit_next = coin_sum[CREDIT_W-1:0];
               state_next  = CREDIT;
            end
         end

         CREDIT: begin
            if (i_cancel) begin
               reject_next = coin_any;
               state_next  = CHANGE;
            end else if (sel_valid) begin
               reject_next = coin_any;
               credit_next = o_credit - PRICE_C;
               vend_next   = sel_onehot;
               state_next  = VEND;
            end else begin
               sel_err_next = sel_any;
               reject_next  = coin_reject_normal;
               if (coin_accept) begin
                  credit_next = coin_sum[CREDIT_W-1:0];
               end
            end
         end

         VEND: begin
            reject_next = coin_any;
            if (o_credit != '0) begin
               state_next = CHANGE;
            end else begin
               state_next = IDLE;
            end
         end

         CHANGE: begin
            reject_next = coin_any;
            if (o_credit > ONE_C) begin
               credit_next = o_credit - ONE_C;
            end else begin
               credit_next = '0;
               state_next  = IDLE;
            end
         end

         default: begin
            credit_next = '0;
            state_next  = IDLE;
         end
      endcase

      change_next = (state_next == CHANGE);
      busy_next   = (state_next == VEND) || (state_next == CHANGE);
   end

   // State and output registers. Reset is asynchronous, so pulling reset_n
   // low clears everything at once, even in the middle of a vend or a
   // change payout. Any change still owed is lost at that point. The first
   // edge after release is an ordinary IDLE cycle.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         o_credit        <= '0;
         o_vend          <= '0;
         o_change_nickle <= 1'b0;
         o_coin_reject   <= 1'b0;
         o_sel_err       <= 1'b0;
         o_busy          <= 1'b0;
      end else begin
         state           <= state_next;
         o_credit        <= credit_next;
         o_vend          <= vend_next;
         o_change_nickle <= change_next;
         o_coin_reject   <= reject_next;
         o_sel_err       <= sel_err_next;
         o_busy          <= busy_next;
      end
   end

`ifdef VEND_AUDIT_EN
   // Sales audit counter. It counts each entry into VEND and sticks at
   // all-ones instead of wrapping, so an overflowed count is obvious to
   // whoever reads the machine.
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         o_sales_cnt <= '0;
      end else if ((state_next == VEND) && (state != VEND) &&
                   (o_sales_cnt != 16'hFFFF)) begin
         o_sales_cnt <= o_sales_cnt + 16'd1;
      end
   end
`endif

endmodule
